// File: rtl/csr_exec_pkg.sv
// ============================================================================
// Module  : csr_exec_pkg
// Brief   : Shared CSR executor definitions: op codes, FSM states, MSR addresses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_exec_pkg;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_RW      = 2'b01;
  localparam logic [1:0] OP_RS      = 2'b10;
  localparam logic [1:0] OP_RC      = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_WAIT = 3'd2;
  localparam state_t ST_WR_REQ  = 3'd3;
  localparam state_t ST_WR_WAIT = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // A CSRRW targeting x0 must not produce a read side effect.
  function automatic logic rd_needed(input logic [1:0] op, input logic rd_zero);
    return !((op == OP_RW) && rd_zero);
  endfunction

  // Set/clear with a zero source must not produce a write side effect.
  function automatic logic wr_needed(input logic [1:0] op, input logic src_zero);
    return !(((op == OP_RS) || (op == OP_RC)) && src_zero);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_rmw_alu.sv
// ============================================================================
// Module  : csr_rmw_alu
// Brief   : Combinational read-modify-write value for CSRRW/CSRRS/CSRRC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_rmw_alu
  import csr_exec_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic [1:0]                op_i,
  input  logic [CSR_DATA_WIDTH-1:0] old_i,
  input  logic [CSR_DATA_WIDTH-1:0] operand_i,
  output logic [CSR_DATA_WIDTH-1:0] new_o
);

  always_comb begin
    new_o = '0;
    case (op_i)
      OP_RW:   new_o = operand_i;
      OP_RS:   new_o = old_i | operand_i;
      OP_RC:   new_o = old_i & ~operand_i;
      default: new_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/csr_exec.sv
// ============================================================================
// Module  : csr_exec
// Brief   : CSR instruction executor sequencing read/write strobes to a responder.
//           Optional wait-state timeout enabled by defining CSR_EXEC_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_exec
  import csr_exec_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] req_operand_i,
  input  logic                      req_src_zero_i,
  input  logic                      req_rd_zero_i,
  output logic                      csr_en_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  input  logic                      csr_busy_i,
  input  logic                      csr_exists_i,
  input  logic                      csr_ro_i,
  output logic                      result_valid_o,
  output logic [CSR_DATA_WIDTH-1:0] result_data_o,
  output logic                      result_err_o
);

  state_t                    state_q, state_d;
  logic [1:0]                op_q;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [CSR_DATA_WIDTH-1:0] operand_q;
  logic [CSR_DATA_WIDTH-1:0] rdata_q;
  logic                      wr_need_q;
  logic                      err_q;

  logic w_accept;
  logic w_in_req;
  logic w_in_wait;
  logic w_fault;
  logic w_issue;
  logic w_timeout;

  assign w_accept  = req_valid_i && (state_q == ST_IDLE);
  assign w_in_req  = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign w_in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);

  // A read-only CSR faults as early as the read phase when a write will follow.
  assign w_fault = w_in_req &&
                   (!csr_exists_i ||
                    (csr_ro_i && ((state_q == ST_WR_REQ) || wr_need_q)));

  // Strobe only when the responder is idle so en never overlaps busy.
  assign w_issue = w_in_req && !w_fault && !csr_busy_i;

`ifdef CSR_EXEC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  assign w_timeout = w_in_wait && !csr_busy_i &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (w_in_wait && !csr_busy_i && !w_timeout) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_op_i == OP_ILLEGAL) begin
            state_d = ST_DONE;
          end else if (rd_needed(req_op_i, req_rd_zero_i)) begin
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (w_fault) begin
          state_d = ST_DONE;
        end else if (w_issue) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (w_fault) begin
          state_d = ST_DONE;
        end else if (w_issue) begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (csr_busy_i) begin
          state_d = wr_need_q ? ST_WR_REQ : ST_DONE;
        end else if (w_timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WR_WAIT: begin
        if (csr_busy_i || w_timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o    = 1'b0;
    csr_en_o       = 1'b0;
    csr_we_o       = 1'b0;
    result_valid_o = 1'b0;
    result_err_o   = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready_o = 1'b1;
      ST_RD_REQ: csr_en_o    = w_issue;
      ST_WR_REQ: begin
        csr_en_o = w_issue;
        csr_we_o = w_issue;
      end
      ST_DONE: begin
        result_valid_o = 1'b1;
        result_err_o   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= OP_ILLEGAL;
      addr_q    <= '0;
      operand_q <= '0;
      rdata_q   <= '0;
      wr_need_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (w_accept) begin
        op_q      <= req_op_i;
        addr_q    <= req_addr_i;
        operand_q <= req_operand_i;
        rdata_q   <= '0;
        wr_need_q <= wr_needed(req_op_i, req_src_zero_i);
        err_q     <= (req_op_i == OP_ILLEGAL);
      end
      if (w_fault || w_timeout) begin
        err_q <= 1'b1;
      end
      if ((state_q == ST_RD_WAIT) && csr_busy_i) begin
        rdata_q <= csr_data_i;
      end
    end
  end

  csr_rmw_alu #(
    .CSR_DATA_WIDTH(CSR_DATA_WIDTH)
  ) u_rmw_alu (
    .op_i     (op_q),
    .old_i    (rdata_q),
    .operand_i(operand_q),
    .new_o    (csr_data_o)
  );

  assign csr_addr_o    = addr_q;
  assign result_data_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_exec.sv
// ============================================================================
// Module  : tb_csr_exec
// Brief   : Scoreboard bench for csr_exec with a one-cycle-busy CSR responder model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_exec;
  import csr_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'b00;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_operand_i = '0;
  logic        req_src_zero_i = 1'b0;
  logic        req_rd_zero_i = 1'b0;
  logic        csr_en_o, csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic [31:0] csr_data_i = '0;
  logic        csr_busy_i = 1'b0;
  logic        csr_exists_i = 1'b1;
  logic        csr_ro_i = 1'b0;
  logic        result_valid_o;
  logic [31:0] result_data_o;
  logic        result_err_o;

  always #5 clk = ~clk;

  csr_exec dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_operand_i(req_operand_i),
    .req_src_zero_i(req_src_zero_i), .req_rd_zero_i(req_rd_zero_i),
    .csr_en_o(csr_en_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .csr_data_i(csr_data_i), .csr_busy_i(csr_busy_i),
    .csr_exists_i(csr_exists_i), .csr_ro_i(csr_ro_i),
    .result_valid_o(result_valid_o), .result_data_o(result_data_o),
    .result_err_o(result_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    int          acc;
    int          rd0;
    int          wr0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          res_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic        stall = 1'b0;
  bit   [31:0] mem [4096];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Responder: acknowledges each strobe with a one-cycle busy pulse and read data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_ni) begin
      csr_busy_i <= 1'b0;
    end else begin
      csr_busy_i <= csr_en_o && !stall;
      if (csr_en_o) begin
        if (csr_we_o) begin
          wr_cnt                <= wr_cnt + 1;
          last_wdata            <= csr_data_o;
          mem[int'(csr_addr_o)] <= csr_data_o;
        end else begin
          rd_cnt     <= rd_cnt + 1;
          csr_data_i <= mem[int'(csr_addr_o)];
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && csr_en_o) chk("en_while_busy", {31'd0, csr_busy_i}, 32'd0);
      if (rst_ni && result_valid_o) begin
        res_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_data", result_data_o, e.data);
          chk("result_err", {31'd0, result_err_o}, {31'd0, e.err});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("read_count", 32'(rd_cnt - e.rd0), 32'(e.nrd));
          chk("write_count", 32'(wr_cnt - e.wr0), 32'(e.nwr));
          if (e.nwr > 0) chk("write_data", last_wdata, e.wdata);
        end
      end
    end
  end

  task automatic start(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] opnd,
                       input logic src_zero, input logic rd_zero);
    int n;
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_op_i       = op;
    req_addr_i     = addr;
    req_operand_i  = opnd;
    req_src_zero_i = src_zero;
    req_rd_zero_i  = rd_zero;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] opnd,
                       input logic src_zero, input logic rd_zero,
                       input logic [31:0] data, input logic err, input int lat,
                       input int nrd, input int nwr, input logic [31:0] wdata);
    exp_t e;
    int   n;
    start(op, addr, opnd, src_zero, rd_zero);
    e.data = data; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    e.wdata = wdata; e.acc = cyc; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
    sb.push_back(e);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin : driver
    int res0;
    mem[12'h340] = 32'h0000_0000;
    mem[12'h300] = 32'h0000_0001;
    mem[12'h305] = 32'h0000_00FF;
    mem[12'h342] = 32'h0000_0010;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_en", {30'd0, csr_en_o, csr_we_o}, 32'd0);
    chk("rst_valid_err", {30'd0, result_valid_o, result_err_o}, 32'd0);
    chk("rst_result_data", result_data_o, 32'd0);
    chk("rst_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("rst_wdata", csr_data_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // op, addr, operand, src_zero, rd_zero, data, err, lat, nrd, nwr, wdata
    issue(OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 5, 1, 1, 32'hDEAD_BEEF);
    issue(OP_RS, CSR_MSTATUS,  32'h8,         1'b0, 1'b0, 32'h1, 1'b0, 5, 1, 1, 32'h9);
    issue(OP_RS, CSR_MSTATUS,  32'h8,         1'b1, 1'b0, 32'h9, 1'b0, 3, 1, 0, 32'h0);
    issue(OP_RC, CSR_MTVEC,    32'h0000_000F, 1'b0, 1'b0, 32'hFF, 1'b0, 5, 1, 1, 32'hF0);
    issue(OP_RW, CSR_MEPC,     32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b0, 3, 0, 1, 32'h1234_5678);
    issue(OP_ILLEGAL, 12'h301, 32'h5,         1'b0, 1'b0, 32'h0, 1'b1, 1, 0, 0, 32'h0);

    csr_ro_i = 1'b1;
    issue(OP_RW, 12'h343,      32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    issue(OP_RW, 12'h345,      32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    issue(OP_RS, CSR_MSTATUS,  32'h0,         1'b1, 1'b0, 32'h9, 1'b0, 3, 1, 0, 32'h0);
    csr_ro_i = 1'b0;

    csr_exists_i = 1'b0;
    issue(OP_RS, 12'h344,      32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    csr_exists_i = 1'b1;

    stall = 1'b1;
`ifdef CSR_EXEC_TIMEOUT_EN
    issue(OP_RW, CSR_MCAUSE,   32'h5,         1'b0, 1'b0, 32'h0, 1'b1, 10, 1, 0, 32'h0);
    start(OP_RW, CSR_MCAUSE, 32'h5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
`else
    res0 = res_cnt;
    start(OP_RW, CSR_MCAUSE, 32'h5, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("no_result_stalled", 32'(res_cnt - res0), 32'd0);
`endif

    // Reset while parked in RD_WAIT with live address and write data.
    res0 = res_cnt;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_en", {30'd0, csr_en_o, csr_we_o}, 32'd0);
    chk("midrst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("midrst_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("midrst_wdata", csr_data_o, 32'd0);
    @(negedge clk);
    stall  = 1'b0;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", 32'(res_cnt - res0), 32'd0);
    issue(OP_RS, CSR_MCAUSE,   32'h3,         1'b0, 1'b0, 32'h10, 1'b0, 5, 1, 1, 32'h13);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
